fir_output_quantizer: RTL and testbench

//  Downstream stage of the FIR filter: accepts the full-precision signed accumulator sum on AXI-Stream.

---
 rtl/fir_output_quantizer.sv | 84 ++++++++
 tb/tb_fir_output_quantizer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_quantizer.sv
// rtl/fir_output_quantizer.sv - round, shift and saturate FIR accumulator sums onto an output stream
// Two-stage pipeline with a single global advance; sat_count tracks clipped output beats.
module fir_output_quantizer #(
  parameter int IN_W  = 37,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int ROUND = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  input  logic             sat_clr,
  output logic [15:0]      sat_count
);

  localparam logic signed [IN_W:0] RND_ADD =
    (ROUND != 0) ? ({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic                    adv;
  logic signed [IN_W:0]    sum_ext;
  logic                    v1;
  logic                    l1;
  logic signed [IN_W:0]    r1;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [OUT_W-1:0]        sat_val;

  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = adv;

  // One guard bit so the rounding add on the largest positive sum cannot wrap.
  assign sum_ext = $signed({s_axis_tdata[IN_W-1], s_axis_tdata}) + RND_ADD;

  assign sat_hi = (r1 > MAX_V);
  assign sat_lo = (r1 < MIN_V);

  always_comb begin
    sat_val = r1[OUT_W-1:0];
    if (sat_hi) begin
      sat_val = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (sat_lo) begin
      sat_val = {1'b1, {(OUT_W - 1){1'b0}}};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1            <= 1'b0;
      l1            <= 1'b0;
      r1            <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (adv) begin
      v1            <= s_axis_tvalid;
      l1            <= s_axis_tvalid && s_axis_tlast;
      r1            <= sum_ext >>> SHIFT;
      m_axis_tvalid <= v1;
      m_axis_tlast  <= l1;
      m_axis_tdata  <= sat_val;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (adv && v1 && (sat_hi || sat_lo) && (sat_count != CNT_MAX)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// tb/tb_fir_output_quantizer.sv - directed vector bench for fir_output_quantizer
module tb_fir_output_quantizer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [36:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;

  fir_output_quantizer #(.IN_W(37), .OUT_W(16), .SHIFT(15), .ROUND(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic signed [36:0] din;
    logic               last;
    logic [15:0]        dout;
    logic               sat;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    int sc;
    int sent;
    int got;
    int cyc;
    logic stall;

    tbl[0]  = '{37'sd49151,        1'b0, 16'h0001, 1'b0};
    tbl[1]  = '{37'sd114688,       1'b0, 16'h0004, 1'b0};
    tbl[2]  = '{-37'sd49152,       1'b0, 16'hFFFF, 1'b0};
    tbl[3]  = '{37'sd0,            1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{37'sd2147483648,   1'b0, 16'h7FFF, 1'b1};
    tbl[5]  = '{-37'sd2147483648,  1'b0, 16'h8000, 1'b1};
    tbl[6]  = '{37'sd1073709056,   1'b0, 16'h7FFF, 1'b0};
    tbl[7]  = '{-37'sd1073741824,  1'b0, 16'h8000, 1'b0};
    tbl[8]  = '{37'sd1073725440,   1'b0, 16'h7FFF, 1'b1};
    tbl[9]  = '{-37'sd16385,       1'b0, 16'hFFFF, 1'b0};
    tbl[10] = '{-37'sd16384,       1'b0, 16'h0000, 1'b0};
    tbl[11] = '{37'sd68719476735,  1'b0, 16'h7FFF, 1'b1};
    tbl[12] = '{-37'sd68719476736, 1'b0, 16'h8000, 1'b1};
    tbl[13] = '{37'sd32768,        1'b0, 16'h0001, 1'b0};
    tbl[14] = '{37'sd65536,        1'b0, 16'h0002, 1'b0};
    tbl[15] = '{37'sd98304,        1'b0, 16'h0003, 1'b0};
    tbl[16] = '{37'sd131072,       1'b1, 16'h0004, 1'b0};

    // reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_sat_count", sat_count, 0);
    aresetn = 1'b1;
    step;

    // table: back-to-back beats, each result two edges after acceptance
    sc = 0;
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = tbl[i].din;
        s_axis_tlast  = tbl[i].last;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      #1;
      chk("s_tready_free", s_axis_tready, 1);
      @(posedge aclk);
      #1;
      if (i >= 1) begin
        if (tbl[i-1].sat) sc++;
        chk($sformatf("vec%0d_valid", i-1), m_axis_tvalid, 1);
        chk($sformatf("vec%0d_data", i-1), m_axis_tdata, tbl[i-1].dout);
        chk($sformatf("vec%0d_last", i-1), m_axis_tlast, tbl[i-1].last);
        chk($sformatf("vec%0d_satcnt", i-1), sat_count, sc);
      end else begin
        chk("first_latency", m_axis_tvalid, 0);
      end
    end
    step;
    chk("idle_tvalid_drop", m_axis_tvalid, 0);
    chk("idle_tlast", m_axis_tlast, 0);

    // backpressure: downstream not ready on cycles 3..7
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      s_axis_tvalid = (sent < 6);
      s_axis_tdata  = 37'((sent + 1) * 32768);
      s_axis_tlast  = 1'b0;
      m_axis_tready = !(c >= 3 && c <= 7);
      #1;
      chk($sformatf("stall_s_tready_c%0d", c), s_axis_tready, m_axis_tready);
      if (s_axis_tvalid && s_axis_tready) sent++;
      stall = m_axis_tvalid && !m_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        chk($sformatf("stall_order%0d", got), m_axis_tdata, got + 1);
        got++;
      end
      @(posedge aclk);
      #1;
      if (stall) begin
        chk("stall_hold_valid", m_axis_tvalid, 1);
        chk("stall_hold_data", m_axis_tdata, got + 1);
      end
    end
    chk("stall_beats_out", got, 6);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step;
    chk("stall_no_extra", m_axis_tvalid, 0);

    // saturation counter: drive to the ceiling, check it sticks, then clear
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 37'sd2147483648;
    cyc = 0;
    while (sat_count != 16'hFFFF && cyc < 70000) begin
      step;
      cyc++;
    end
    chk("sat_reach_max", sat_count, 16'hFFFF);
    repeat (3) step;
    chk("sat_sticky", sat_count, 16'hFFFF);
    sat_clr = 1'b1;
    step;
    chk("sat_clr_prio", sat_count, 0);
    sat_clr = 1'b0;
    s_axis_tvalid = 1'b0;
    step;
    chk("sat_after_clr", sat_count, 1);
    repeat (2) step;
    chk("sat_bubbles", sat_count, 1);

    // reset with two beats in flight
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 37'sd163840;
    step;
    s_axis_tdata  = 37'sd196608;
    step;
    chk("pre_rst_data", m_axis_tdata, 16'h0005);
    aresetn = 1'b0;
    s_axis_tdata = 37'sd229376;
    step;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_satcnt", sat_count, 0);
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("rst_flush%0d", k), m_axis_tvalid, 0);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 37'sd98304;
    step;
    s_axis_tvalid = 1'b0;
    chk("post_rst_lat1", m_axis_tvalid, 0);
    step;
    chk("post_rst_valid", m_axis_tvalid, 1);
    chk("post_rst_data", m_axis_tdata, 16'h0003);
    step;
    chk("post_rst_drop", m_axis_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
